// File: rtl/phys_free_list_if.sv
// Handshake bundle between the rename stage and the physical-register free list.
// The master side (ROB retire + dispatch) drives push/pop requests; the slave
// side (the free list itself) returns the head tag, occupancy and error status.
interface phys_free_list_if #(
    parameter int PHYS_REG_SZ = 64,
    parameter int ARCH_REG_SZ = 32
);
    localparam int FL_SZ = PHYS_REG_SZ - ARCH_REG_SZ;
    localparam int TAG_W = $clog2(PHYS_REG_SZ);
    localparam int CNT_W = $clog2(FL_SZ + 1);

    // Retire side: t_old tags returned to the pool
    logic             push_en;
    logic [TAG_W-1:0] push_tag;
    // Dispatch side: consume the tag currently presented
    logic             pop_en;
    logic [TAG_W-1:0] free_tag;
    logic             free_valid;
    // Status
    logic [CNT_W-1:0] count;
    logic             full;
    logic             overflow_err;

    modport master (
        output push_en, push_tag, pop_en,
        input  free_tag, free_valid, count, full, overflow_err
    );

    modport slave (
        input  push_en, push_tag, pop_en,
        output free_tag, free_valid, count, full, overflow_err
    );
endinterface

// File: rtl/phys_free_list.sv
// Free list of physical register indices for an R10K-style rename stage.
// Circular FIFO of FL_SZ = PHYS_REG_SZ - ARCH_REG_SZ entries; at reset it holds
// ARCH_REG_SZ..PHYS_REG_SZ-1 in order (PRs below ARCH_REG_SZ are the initial
// architectural mappings). Retired t_old tags are pushed at the tail, dispatch
// pops the head. PR0 is never freed, so pushes of tag 0 are ignored.
//
// Optional build macro FREELIST_BYPASS_EN: when the list is empty, a push is
// forwarded combinationally to free_tag/free_valid in the same cycle, and a
// same-cycle pop consumes it directly.
module phys_free_list #(
    parameter int PHYS_REG_SZ = 64,
    parameter int ARCH_REG_SZ = 32
) (
    input  logic            clock,
    input  logic            reset,
    phys_free_list_if.slave fl
);
    localparam int FL_SZ = PHYS_REG_SZ - ARCH_REG_SZ;
    localparam int TAG_W = $clog2(PHYS_REG_SZ);
    localparam int PTR_W = $clog2(FL_SZ);
    localparam int CNT_W = $clog2(FL_SZ + 1);

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FL_SZ);
    localparam logic [PTR_W-1:0] PTR_LAST = PTR_W'(FL_SZ - 1);

    // Storage and bookkeeping
    logic [TAG_W-1:0] r_entry [FL_SZ];
    logic [PTR_W-1:0] r_head;
    logic [PTR_W-1:0] r_tail;
    logic [CNT_W-1:0] r_count;
    logic             r_overflow;

    // Request qualification
    logic             w_push_req;
    logic             w_empty;
    logic             w_full;
    logic             w_bypass;
    logic             w_pop_ok;
    logic             w_push_ok;
    logic             w_push_drop;

    // Next-state values
    logic [PTR_W-1:0] w_head_nxt;
    logic [PTR_W-1:0] w_tail_nxt;
    logic [CNT_W-1:0] w_count_nxt;
    logic             w_overflow_nxt;

    // Output values
    logic [TAG_W-1:0] w_free_tag;
    logic             w_free_valid;

    // Pointer increment with wrap at FL_SZ-1, so FL_SZ need not be a power of two
    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] p);
        return (p == PTR_LAST) ? '0 : p + 1'b1;
    endfunction

    assign w_empty    = (r_count == '0);
    assign w_full     = (r_count == CNT_FULL);
    assign w_push_req = fl.push_en && (fl.push_tag != '0);

`ifdef FREELIST_BYPASS_EN
    // An empty list can hand a freshly retired tag straight to dispatch
    assign w_bypass = w_empty && w_push_req;
`else
    assign w_bypass = 1'b0;
`endif

    // Pop needs something to hand out: a stored tag, or the bypassed push.
    assign w_pop_ok    = fl.pop_en && (!w_empty || w_bypass);
    // A full list still accepts a push when a pop frees a slot in the same cycle.
    assign w_push_ok   = w_push_req && (!w_full || w_pop_ok);
    assign w_push_drop = w_push_req && w_full && !w_pop_ok;

    // Next-state computation for pointers, occupancy and the sticky error
    always_comb begin
        // NOTE: every always_comb output gets a default on entry; a path that
        // leaves one unassigned would infer a latch.
        w_head_nxt     = r_head;
        w_tail_nxt     = r_tail;
        w_count_nxt    = r_count;
        w_overflow_nxt = r_overflow || w_push_drop;

        if (w_pop_ok) begin
            w_head_nxt = ptr_inc(r_head);
        end
        if (w_push_ok) begin
            w_tail_nxt = ptr_inc(r_tail);
        end

        // Both accepted (including the bypass case) leaves occupancy unchanged
        unique case ({w_push_ok, w_pop_ok})
            2'b10:   w_count_nxt = r_count + 1'b1;
            2'b01:   w_count_nxt = r_count - 1'b1;
            default: w_count_nxt = r_count;
        endcase
    end

    // Head tag presented to dispatch, with optional empty-list forwarding
    always_comb begin
        w_free_tag   = r_entry[r_head];
        w_free_valid = !w_empty;
        if (w_bypass) begin
            w_free_tag   = fl.push_tag;
            w_free_valid = 1'b1;
        end
    end

    // Control state register; reset wins over any same-cycle push or pop
    always_ff @(posedge clock) begin
        // NOTE: sequential state uses non-blocking assignments so every register
        // samples pre-edge values regardless of statement order.
        if (reset) begin
            r_head     <= '0;
            r_tail     <= '0;
            r_count    <= CNT_FULL;
            r_overflow <= 1'b0;
        end else begin
            r_head     <= w_head_nxt;
            r_tail     <= w_tail_nxt;
            r_count    <= w_count_nxt;
            r_overflow <= w_overflow_nxt;
        end
    end

    // Tag storage: reset preloads the non-architectural PRs in ascending order
    always_ff @(posedge clock) begin
        // NOTE: this array is reset on purpose, because its reset contents are
        // the initial pool of free registers; plain data buffers are normally
        // left unreset so they can map to RAM.
        if (reset) begin
            for (int i = 0; i < FL_SZ; i++) begin
                r_entry[i] <= TAG_W'(ARCH_REG_SZ + i);
            end
        end else if (w_push_ok) begin
            r_entry[r_tail] <= fl.push_tag;
        end
    end

    assign fl.free_tag     = w_free_tag;
    assign fl.free_valid   = w_free_valid;
    assign fl.count        = r_count;
    assign fl.full         = w_full;
    assign fl.overflow_err = r_overflow;

    // Occupancy can never exceed the list depth
    a_count_bound: assert property (@(posedge clock) disable iff (reset)
        r_count <= CNT_FULL);

    // A valid head without bypass implies stored entries
    a_valid_consistent: assert property (@(posedge clock) disable iff (reset)
        (fl.free_valid && !w_bypass) |-> !w_empty);

endmodule
